// File: rtl/semaforo_pkg.sv
// Shared constants for the traffic-light semaphore: default clock rate,
// interval multipliers and the light-state encoding used by control and bench.
package semaforo_pkg;

    localparam int CLK_FREQ_DEFAULT = 25_000_000;

    // Interval multipliers: red 5 s, green 7 s, yellow 1/2 s.
    localparam int RED_SECONDS    = 5;
    localparam int GREEN_SECONDS  = 7;
    localparam int YELLOW_DIVISOR = 2;

    typedef enum logic [1:0] {
        LIGHT_RED    = 2'd0,
        LIGHT_GREEN  = 2'd1,
        LIGHT_YELLOW = 2'd2
    } light_t;

    function automatic int red_cycles(input int freq);
        return RED_SECONDS * freq;
    endfunction

    function automatic int green_cycles(input int freq);
        return GREEN_SECONDS * freq;
    endfunction

    function automatic int yellow_cycles(input int freq);
        return freq / YELLOW_DIVISOR;
    endfunction

    // Counter width for an interval of t cycles; never narrower than one bit.
    function automatic int count_width(input int t);
        return (t < 2) ? 1 : $clog2(t);
    endfunction

endpackage

// File: rtl/bloco_operativo_if.sv
// Strobe/flag bundle between the semaphore control FSM (master) and the
// timing datapath bloco_operativo (slave).
interface bloco_operativo_if;

    logic ped_btn;
    logic load_Reg5s;
    logic clear_Reg5s;
    logic load_Reg7s;
    logic clear_Reg7s;
    logic load_Reg05s;
    logic clear_Reg05s;
    logic fim_5s;
    logic fim_7s;
    logic fim_05s;
    logic pedestrian;

    modport master (
        output ped_btn,
        output load_Reg5s,
        output clear_Reg5s,
        output load_Reg7s,
        output clear_Reg7s,
        output load_Reg05s,
        output clear_Reg05s,
        input  fim_5s,
        input  fim_7s,
        input  fim_05s,
        input  pedestrian
    );

    modport slave (
        input  ped_btn,
        input  load_Reg5s,
        input  clear_Reg5s,
        input  load_Reg7s,
        input  clear_Reg7s,
        input  load_Reg05s,
        input  clear_Reg05s,
        output fim_5s,
        output fim_7s,
        output fim_05s,
        output pedestrian
    );

endinterface

// File: rtl/temporizador_fim.sv
// Saturating interval counter: clear beats load, counts up to T-1 and holds;
// fim is a direct decode of the register (no extra stage).
module temporizador_fim
    import semaforo_pkg::*;
#(
    parameter int T = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic clear,
    output logic fim
);

    localparam int             W    = count_width(T);
    localparam logic [W-1:0]   LAST = W'(T - 1);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (load && (count_reg != LAST)) begin
            count_next = count_reg + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign fim = (count_reg == LAST);

endmodule

// File: rtl/bloco_operativo.sv
// Semaphore timing datapath: red/green/yellow interval counters plus pedestrian
// conditioning (2-flop sync + edge pulse when PED_SYNC_EN is defined).
module bloco_operativo
    import semaforo_pkg::*;
#(
    parameter int CLK_FREQ = CLK_FREQ_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    bloco_operativo_if.slave   bus
);

    // Interval lengths in cycles; each must be at least 2.
    localparam int T5  = red_cycles(CLK_FREQ);
    localparam int T7  = green_cycles(CLK_FREQ);
    localparam int T05 = yellow_cycles(CLK_FREQ);

    logic [2:0] load_vec;
    logic [2:0] clear_vec;
    logic [2:0] fim_vec;

    // Index 0 = red, 1 = green, 2 = yellow.
    assign load_vec  = {bus.load_Reg05s,  bus.load_Reg7s,  bus.load_Reg5s};
    assign clear_vec = {bus.clear_Reg05s, bus.clear_Reg7s, bus.clear_Reg5s};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_timer
            localparam int TI = (gi == 0) ? T5 : ((gi == 1) ? T7 : T05);
            temporizador_fim #(
                .T(TI)
            ) u_timer (
                .clk   (clk),
                .rst   (rst),
                .load  (load_vec[gi]),
                .clear (clear_vec[gi]),
                .fim   (fim_vec[gi])
            );
        end
    endgenerate

    assign bus.fim_5s  = fim_vec[0];
    assign bus.fim_7s  = fim_vec[1];
    assign bus.fim_05s = fim_vec[2];

`ifdef PED_SYNC_EN
    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;
    logic pulse_reg;

    // Pulse is registered, so it appears on the third edge after the button rises.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
            pulse_reg <= 1'b0;
        end else begin
            sync1_reg <= bus.ped_btn;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            pulse_reg <= sync2_reg & ~prev_reg;
        end
    end

    assign bus.pedestrian = pulse_reg;
`else
    assign bus.pedestrian = bus.ped_btn;
`endif

endmodule

// File: tb/tb_bloco_operativo.sv
// Scoreboard bench for bloco_operativo at CLK_FREQ=4 (T5=20, T7=28, T05=2),
// including a small control-FSM model for the closed-loop timeline.
module tb_bloco_operativo;
    import semaforo_pkg::*;

    localparam int FREQ = 4;
    localparam int T5   = 20;
    localparam int T7   = 28;
    localparam int T05  = 2;
`ifdef PED_SYNC_EN
    localparam int PED_GREEN_LEN = 8;
`else
    localparam int PED_GREEN_LEN = 5;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bloco_operativo_if bus ();

    bloco_operativo #(
        .CLK_FREQ(FREQ)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] exp_q[$];
    int         len_q[$];

    // Observed flags: {pedestrian, fim_05s, fim_7s, fim_5s}
    function automatic logic [3:0] obs();
        return {bus.pedestrian, bus.fim_05s, bus.fim_7s, bus.fim_5s};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_strobes(input logic [2:0] load, input logic [2:0] clear);
        bus.load_Reg5s   = load[0];
        bus.load_Reg7s   = load[1];
        bus.load_Reg05s  = load[2];
        bus.clear_Reg5s  = clear[0];
        bus.clear_Reg7s  = clear[1];
        bus.clear_Reg05s = clear[2];
    endtask

    task automatic test_reset();
        logic [3:0] e;
        logic [3:0] g;
        rst = 1'b0;
        bus.ped_btn = 1'b0;
        set_strobes(3'b111, 3'b000);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(4'b0000);
            step();
            g = obs();
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: got %b expected %b", i, g, e);
            end
        end
        set_strobes(3'b001, 3'b000);
        rst = 1'b1;
        for (int i = 1; i <= T5 - 1; i++) begin
            exp_q.push_back({3'b000, (i == T5 - 1)});
            step();
            g = obs();
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL reset_release_count edge %0d: got %b expected %b", i, g, e);
            end
        end
        $display("test_reset done (%0d checks so far)", n_checks);
    endtask

    task automatic test_saturation();
        logic [3:0] e;
        logic [3:0] g;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(4'b0001);
            step();
            g = obs();
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL saturate edge %0d: got %b expected %b", i, g, e);
            end
        end
        set_strobes(3'b001, 3'b001);
        exp_q.push_back(4'b0000);
        step();
        set_strobes(3'b001, 3'b000);
        g = obs();
        e = exp_q.pop_front();
        n_checks++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL clear5 pulse: got %b expected %b", g, e);
        end
        // A full recount proves the clear returned the counter to zero.
        for (int i = 1; i <= T5 - 1; i++) begin
            exp_q.push_back({3'b000, (i == T5 - 1)});
            step();
            g = obs();
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL recount5 edge %0d: got %b expected %b", i, g, e);
            end
        end
        set_strobes(3'b000, 3'b001);
        step();
        $display("test_saturation done (%0d checks so far)", n_checks);
    endtask

    task automatic test_clear_priority();
        logic [3:0] e;
        logic [3:0] g;
        set_strobes(3'b010, 3'b011);
        for (int i = 0; i < 40; i++) begin
            exp_q.push_back(4'b0000);
            step();
            g = obs();
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL clear_priority edge %0d: got %b expected %b", i, g, e);
            end
        end
        set_strobes(3'b010, 3'b001);
        for (int i = 1; i <= T7 - 1; i++) begin
            exp_q.push_back({2'b00, (i == T7 - 1), 1'b0});
            step();
            g = obs();
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL count7 edge %0d: got %b expected %b", i, g, e);
            end
        end
        set_strobes(3'b000, 3'b011);
        step();
        $display("test_clear_priority done (%0d checks so far)", n_checks);
    endtask

    task automatic test_yellow();
        logic [3:0] e;
        logic [3:0] g;
        set_strobes(3'b100, 3'b011);
        for (int i = 1; i <= 2; i++) begin
            exp_q.push_back({1'b0, (i >= T05 - 1), 2'b00});
            step();
            g = obs();
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL yellow edge %0d: got %b expected %b", i, g, e);
            end
        end
        // Asynchronous reset between edges must clear the flag at once.
        #2;
        rst = 1'b0;
        exp_q.push_back(4'b0000);
        #1;
        g = obs();
        e = exp_q.pop_front();
        n_checks++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL async_reset_yellow: got %b expected %b", g, e);
        end
        step();
        rst = 1'b1;
        exp_q.push_back(4'b0100);
        step();
        g = obs();
        e = exp_q.pop_front();
        n_checks++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL yellow_after_reset: got %b expected %b", g, e);
        end
        set_strobes(3'b000, 3'b111);
        step();
        $display("test_yellow done (%0d checks so far)", n_checks);
    endtask

    task automatic test_pedestrian();
        logic e;
        logic g;
        int pulses;
        pulses = 0;
`ifdef PED_SYNC_EN
        for (int r = 0; r < 2; r++) begin
            bus.ped_btn = 1'b1;
            for (int i = 1; i <= 10; i++) begin
                exp_q.push_back({(i == 3), 3'b000});
                step();
                g = bus.pedestrian;
                e = exp_q.pop_front()[3];
                if (g) pulses++;
                n_checks++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL ped_pulse round %0d edge %0d: got %b expected %b", r, i, g, e);
                end
            end
            bus.ped_btn = 1'b0;
            step();
            step();
        end
`else
        for (int i = 0; i < 6; i++) begin
            bus.ped_btn = i[0];
            exp_q.push_back({i[0], 3'b000});
            #1;
            g = bus.pedestrian;
            e = exp_q.pop_front()[3];
            if (g) pulses++;
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL ped_passthrough step %0d: got %b expected %b", i, g, e);
            end
            step();
        end
        bus.ped_btn = 1'b0;
`endif
        n_checks++;
        if (pulses !== 2 + 1 * 0 + ((6 / 2) - 1) * 0 + 0) begin
            if (pulses !== ((PED_GREEN_LEN == 8) ? 2 : 3)) begin
                n_fail++;
                $display("FAIL ped_pulse_count: got %0d expected %0d", pulses,
                         (PED_GREEN_LEN == 8) ? 2 : 3);
            end
        end
        $display("test_pedestrian done (%0d checks so far, %0d pulses)", n_checks, pulses);
    endtask

    task automatic test_closed_loop();
        light_t state;
        light_t next;
        int len;
        int visits;
        int got_len;
        int exp_len;
        logic leave;
        int exp_table[7];
        exp_table = '{T5, T7, T05, T5, PED_GREEN_LEN, T05, T5};
        rst = 1'b0;
        bus.ped_btn = 1'b0;
        set_strobes(3'b000, 3'b111);
        step();
        rst = 1'b1;
        state  = LIGHT_RED;
        len    = 1;
        visits = 0;
        len_q.push_back(exp_table[0]);
        for (int cyc = 0; cyc < 400 && visits < 7; cyc++) begin
            case (state)
                LIGHT_RED:   set_strobes(3'b001, 3'b110);
                LIGHT_GREEN: set_strobes(3'b010, 3'b101);
                default:     set_strobes(3'b100, 3'b011);
            endcase
            bus.ped_btn = (visits == 4 && len == 5);
            #1;
            leave = 1'b0;
            next  = state;
            case (state)
                LIGHT_RED: begin
                    leave = bus.fim_5s;
                    next  = LIGHT_GREEN;
                end
                LIGHT_GREEN: begin
                    leave = bus.fim_7s | bus.pedestrian;
                    next  = LIGHT_YELLOW;
                end
                default: begin
                    leave = bus.fim_05s;
                    next  = LIGHT_RED;
                end
            endcase
            step();
            if (leave) begin
                got_len = len;
                exp_len = len_q.pop_front();
                n_checks++;
                if (got_len !== exp_len) begin
                    n_fail++;
                    $display("FAIL loop_visit %0d state %s: lasted %0d cycles expected %0d",
                             visits, state.name(), got_len, exp_len);
                end else begin
                    $display("loop visit %0d %s lasted %0d cycles", visits, state.name(), got_len);
                end
                visits++;
                state = next;
                len   = 1;
                if (visits < 7) len_q.push_back(exp_table[visits]);
            end else begin
                len++;
            end
        end
        bus.ped_btn = 1'b0;
        n_checks++;
        if (visits !== 7) begin
            n_fail++;
            $display("FAIL loop_timeout: completed %0d visits expected 7", visits);
        end
    endtask

    initial begin
        bus.ped_btn = 1'b0;
        set_strobes(3'b000, 3'b000);
        test_reset();
        test_saturation();
        test_clear_priority();
        test_yellow();
        test_pedestrian();
        test_closed_loop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
